// File: rtl/fc_layer_seq.sv
// -----------------------------------------------------------------------------
// fc_layer_seq
//
// Sequencer wrapped around one combinational fully-connected layer. A serial
// stream of IN activations is collected into a frame register that drives the
// layer inputs. The frame is held stable for SETTLE cycles. All OUT neuron
// results are then captured in parallel and streamed out one per cycle under
// valid/ready. The next frame may load while the current results drain.
//
// Ports
//   clk        in   1          single clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          upstream activation valid
//   in_ready   out  1          block accepts an activation (registered)
//   in_data    in   WIDTH      activation
//   x_out      out  WIDTH*IN   frame register to the layer, word i at [i*WIDTH +: WIDTH]
//   z_in       in   ZW*OUT     layer results, neuron j at [j*ZW +: ZW]
//   out_valid  out  1          result word valid
//   out_ready  in   1          downstream accepts
//   out_data   out  ZW         result word
//   out_last   out  1          marks neuron OUT-1 of a frame
//   busy       out  1          a frame is loading, settling or draining
// -----------------------------------------------------------------------------
module fc_layer_seq #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int OUT    = 10,
  parameter int ZW     = 23,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic [WIDTH*IN-1:0] x_out,
  input  logic [ZW*OUT-1:0]   z_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ZW-1:0]       out_data,
  output logic                out_last,
  output logic                busy
);

  // Index widths, kept at least one bit wide for degenerate parameter values.
  localparam int WW = (IN > 1)     ? $clog2(IN)     : 1;
  localparam int RW = (OUT > 1)    ? $clog2(OUT)    : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no results held
    ST_SETTLE = 2'd1,  // frame frozen while the layer settles
    ST_DRAIN  = 2'd2   // captured results streaming out
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q,      state_d;
  logic [CW-1:0]       cnt_q,        cnt_d;
  logic [RW-1:0]       rd_idx_q,     rd_idx_d;
  logic [ZW*OUT-1:0]   res_q,        res_d;
  logic [WW-1:0]       wr_idx_q,     wr_idx_d;
  logic                frame_full_q, frame_full_d;
  logic [WIDTH*IN-1:0] x_buf_q,      x_buf_d;
  logic                in_ready_q,   in_ready_d;

  // ---------------------------------------------------------------------------
  // Handshake and event decode
  // ---------------------------------------------------------------------------
  logic in_hs;        // activation accepted this cycle
  logic in_wrap;      // accepted activation completes the frame
  logic out_hs;       // result word accepted this cycle
  logic settle_done;  // final settle cycle: capture on this edge

  assign in_hs       = in_valid & in_ready_q;
  assign in_wrap     = in_hs && (wr_idx_q == WW'(IN - 1));
  assign out_hs      = out_valid & out_ready;
  assign settle_done = (state_q == ST_SETTLE) && (cnt_q == CW'(SETTLE - 1));

  // ---------------------------------------------------------------------------
  // Input side: frame loader
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' and give every target a
  // default first, so no path leaves a signal unassigned (no latch).
  always_comb begin
    wr_idx_d     = wr_idx_q;
    frame_full_d = frame_full_q;
    x_buf_d      = x_buf_q;

    if (in_hs) begin
      x_buf_d[int'(wr_idx_q)*WIDTH +: WIDTH] = in_data;
      if (in_wrap) begin
        wr_idx_d     = '0;
        frame_full_d = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + WW'(1);
      end
    end

    // The capture edge consumes the held frame. in_ready is low throughout
    // SETTLE, so no new wrap can coincide with this clear.
    if (settle_done) begin
      frame_full_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output side: settle / capture / drain state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_idx_d = rd_idx_q;
    res_d    = res_q;

    unique case (state_q)
      ST_IDLE: begin
        // Entering SETTLE on the very edge that completes the frame places
        // the capture exactly SETTLE edges after the last accepted word.
        // A frame already held (it completed on the same edge as the final
        // drain handshake) starts settling one edge later.
        if (frame_full_q || in_wrap) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end

      ST_SETTLE: begin
        if (settle_done) begin
          res_d    = z_in;
          rd_idx_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DRAIN: begin
        if (out_hs) begin
          if (out_last) begin
            rd_idx_d = '0;
            cnt_d    = '0;
            // Only a frame already complete before this edge may go
            // straight back to settling; one completing on this same edge
            // is picked up from IDLE on the next edge.
            state_d  = frame_full_q ? ST_SETTLE : ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + RW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // in_ready is registered: it reflects the state the block enters on the
  // coming edge, so it drops right after the frame-completing handshake and
  // rises right after the capture edge.
  assign in_ready_d = !frame_full_d && (state_d != ST_SETTLE);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking '<=' only, so every
  // register samples the pre-edge values of the others.
  // NOTE: the frame buffer and result bank are reset as well as the control
  // state; both are visible on ports (x_out, out_data) and must read zero
  // after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_idx_q     <= '0;
      res_q        <= '0;
      wr_idx_q     <= '0;
      frame_full_q <= 1'b0;
      x_buf_q      <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_idx_q     <= rd_idx_d;
      res_q        <= res_d;
      wr_idx_q     <= wr_idx_d;
      frame_full_q <= frame_full_d;
      x_buf_q      <= x_buf_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = in_ready_q;
  assign x_out     = x_buf_q;
  assign out_valid = (state_q == ST_DRAIN);
  // Gated by DRAIN so the flag is low whenever no result is presented.
  assign out_last  = out_valid && (rd_idx_q == RW'(OUT - 1));
  // Results come straight from the captured bank, untouched.
  assign out_data  = res_q[int'(rd_idx_q)*ZW +: ZW];
  assign busy      = (state_q != ST_IDLE) || (wr_idx_q != '0) || frame_full_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_fc_layer_seq
//
// Bench for fc_layer_seq. A stand-in layer drives z_in from x_out. The bench
// model tracks accepted words by position, the queue of results each complete
// frame must produce, and how many frames are loaded versus started, and
// compares the DUT against it once per cycle on the falling edge. Directed
// sections add literal results and latency expectations.
// -----------------------------------------------------------------------------
module tb_fc_layer_seq;

  localparam int WIDTH  = 8;
  localparam int IN     = 128;
  localparam int OUT    = 10;
  localparam int ZW     = 23;
  localparam int SETTLE = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data = '0;
  logic [WIDTH*IN-1:0] x_out;
  logic [ZW*OUT-1:0]   z_in;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ZW-1:0]       out_data;
  logic                out_last;
  logic                busy;

  fc_layer_seq #(
    .WIDTH (WIDTH),
    .IN    (IN),
    .OUT   (OUT),
    .ZW    (ZW),
    .SETTLE(SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .x_out    (x_out),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Layer weights: even inputs weigh (j+1), odd inputs weigh 2.
  function automatic int wgt(input int i, input int j);
    return (i % 2 == 0) ? (j + 1) : 2;
  endfunction

  // Stand-in combinational layer fed by the DUT frame register.
  function automatic logic [ZW-1:0] layer_eval(input logic [WIDTH*IN-1:0] x, input int j);
    int acc = 0;
    for (int i = 0; i < IN; i++) acc += int'(x[i*WIDTH +: WIDTH]) * wgt(i, j);
    return ZW'(acc);
  endfunction

  always_comb begin
    z_in = '0;
    for (int j = 0; j < OUT; j++) z_in[j*ZW +: ZW] = layer_eval(x_out, j);
  end

  // ---------------------------------------------------------------------------
  // Model state
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [ZW-1:0] d;
    logic          last;
  } exp_t;

  logic [WIDTH-1:0] xm [IN];      // words accepted, by frame position
  exp_t             expq[$];      // results still owed, in order
  int               wr_cnt;       // words of the current partial frame
  int               frames_acc;   // frames fully accepted
  int               frames_started;
  bit               started;      // front frame has begun to appear
  int               edges_since_rst;
  bit               stall_prev;
  logic [ZW-1:0]    data_prev;
  logic             last_prev;
  bit               in_hs_now, out_hs_now, out_end_now, fill_now;
  int               stall_pct;
  int               tests = 0;
  int               fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH*IN-1:0] pack_x();
    logic [WIDTH*IN-1:0] v;
    for (int i = 0; i < IN; i++) v[i*WIDTH +: WIDTH] = xm[i];
    return v;
  endfunction

  task automatic check_x(input string name);
    tests++;
    if (x_out !== pack_x()) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, x_out, pack_x());
    end
  endtask

  // Result neuron j must hold for the frame currently in xm.
  function automatic logic [ZW-1:0] model_z(input int j);
    int acc = 0;
    for (int i = 0; i < IN; i++) acc += int'(xm[i]) * wgt(i, j);
    return ZW'(acc);
  endfunction

  // Test data: seed 0 gives 1,2,3,...; other seeds give a scrambled pattern.
  function automatic logic [WIDTH-1:0] gen(input int seed, input int pos);
    if (seed == 0) return WIDTH'(pos + 1);
    return WIDTH'(seed * 53 + pos * 29 + (pos >> 3));
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cycle compare (falling edge), then record what the next rising edge
  // will accept.
  // ---------------------------------------------------------------------------
  task automatic compare_cycle();
    exp_t e;
    in_hs_now = 1'b0; out_hs_now = 1'b0; out_end_now = 1'b0; fill_now = 1'b0;

    if (!rst_n) begin
      for (int i = 0; i < IN; i++) xm[i] = '0;
      expq.delete();
      wr_cnt = 0; frames_acc = 0; frames_started = 0; started = 1'b0;
      edges_since_rst = 0; stall_prev = 1'b0;
      check("reset in_ready",  64'(in_ready),  64'd0);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_last",  64'(out_last),  64'd0);
      check("reset out_data",  64'(out_data),  64'd0);
      check("reset busy",      64'(busy),      64'd0);
      check_x("reset x_out");
      return;
    end

    if (out_valid && !started && expq.size() > 0) begin
      started = 1'b1;
      frames_started++;
    end

    check_x("x_out");
    check("busy", 64'(busy), 64'((wr_cnt != 0) || (expq.size() != 0)));
    check("in_ready", 64'(in_ready),
          64'((edges_since_rst > 0) && (frames_acc == frames_started)));

    if (stall_prev) begin
      check("stall out_valid", 64'(out_valid), 64'd1);
      check("stall out_data",  64'(out_data),  64'(data_prev));
      check("stall out_last",  64'(out_last),  64'(last_prev));
    end

    if (out_valid) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious out_valid: got 1, expected 0 (t=%0t)", $time);
      end else begin
        check("out_data", 64'(out_data), 64'(expq[0].d));
        check("out_last", 64'(out_last), 64'(expq[0].last));
      end
    end

    stall_prev = out_valid && !out_ready;
    data_prev  = out_data;
    last_prev  = out_last;

    if (in_valid && in_ready) begin
      in_hs_now  = 1'b1;
      xm[wr_cnt] = in_data;
      wr_cnt++;
      if (wr_cnt == IN) begin
        wr_cnt = 0;
        frames_acc++;
        fill_now = 1'b1;
        for (int j = 0; j < OUT; j++) begin
          e.d    = model_z(j);
          e.last = (j == OUT - 1);
          expq.push_back(e);
        end
      end
    end

    if (out_valid && out_ready && expq.size() > 0) begin
      out_hs_now  = 1'b1;
      out_end_now = expq[0].last;
      if (out_end_now) started = 1'b0;
      void'(expq.pop_front());
    end

    edges_since_rst++;
  endtask

  // One clock: compare on the falling edge, return 1 ns after the rising edge.
  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    out_ready = (int'($urandom_range(0, 99)) >= stall_pct);
  endtask

  task automatic set_ready(input int pct);
    stall_pct = pct;
    out_ready = (int'($urandom_range(0, 99)) >= pct);
  endtask

  // Offer words until 'count' have been accepted; gap_pct is the chance of
  // in_valid being low on a given cycle.
  task automatic send_words(input int seed, input int count, input int gap_pct);
    int sent = 0;
    int budget = 0;
    while (sent < count && budget < 4000) begin
      in_valid = (int'($urandom_range(0, 99)) >= gap_pct);
      in_data  = gen(seed, wr_cnt);
      step();
      budget++;
      if (in_hs_now) sent++;
    end
    in_valid = 1'b0;
    check("words accepted", 64'(sent), 64'(count));
  endtask

  // Count cycles until out_valid; in_ready must stay low while waiting.
  task automatic wait_valid(input int exp_n, input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      check({name, " in_ready low"}, 64'(in_ready), 64'd0);
      step();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(exp_n));
  endtask

  task automatic drain_all(input string name);
    int b = 0;
    while (expq.size() > 0 && b < 3000) begin
      step();
      b++;
    end
    check({name, " all results delivered"}, 64'(expq.size()), 64'd0);
  endtask

  task automatic out_handshakes(input int k_req);
    int k = 0;
    int b = 0;
    while (k < k_req && b < 200) begin
      step();
      b++;
      if (out_hs_now) k++;
    end
    check("output handshakes", 64'(k), 64'(k_req));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    stall_pct = 100;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("in_ready before first edge", 64'(in_ready), 64'd0);
    step();
    check("in_ready after first edge", 64'(in_ready), 64'd1);

    // 1: words 1..128, literal results, latency SETTLE.
    set_ready(0);
    send_words(0, IN, 0);
    wait_valid(SETTLE, "t1");
    check("t1 first result", 64'(out_data), 64'd12416);
    check("t1 first last",   64'(out_last), 64'd0);
    repeat (OUT - 1) step();
    check("t1 last result",  64'(out_data), 64'd49280);
    check("t1 last flag",    64'(out_last), 64'd1);
    step();
    check("t1 drained", 64'(out_valid), 64'd0);

    // 2a: back-to-back frames with out_ready tied high.
    send_words(1, IN, 0);
    send_words(2, IN, 0);
    wait_valid(SETTLE, "t2a");
    drain_all("t2a");

    // 2b: next frame complete before the drain ends -> gap of SETTLE cycles.
    set_ready(100);
    send_words(3, IN, 0);
    wait_valid(SETTLE, "t2b first");
    send_words(4, IN, 0);
    set_ready(0);
    out_handshakes(OUT);
    check("t2b last handshake", 64'(out_end_now), 64'd1);
    wait_valid(SETTLE, "t2b gap");
    drain_all("t2b");

    // 3: 30% output stalls.
    set_ready(30);
    send_words(5, IN, 0);
    send_words(6, IN, 0);
    drain_all("t3");

    // 4: random input gaps.
    set_ready(0);
    send_words(7, IN, 40);
    send_words(8, IN, 40);
    drain_all("t4");

    // 5: final input and final output handshake on the same edge.
    set_ready(100);
    send_words(9, IN, 0);
    wait_valid(SETTLE, "t5 first");
    send_words(10, IN - 1, 0);
    set_ready(0);
    out_handshakes(OUT - 1);
    check("t5 out_last presented", 64'(out_last), 64'd1);
    send_words(10, 1, 0);
    check("t5 same-edge handshakes", 64'({fill_now, out_end_now}), 64'd3);
    check("t5 out_valid after", 64'(out_valid), 64'd0);
    check("t5 busy after",      64'(busy),      64'd1);
    wait_valid(SETTLE + 1, "t5 idle gap");
    drain_all("t5");

    // 6: reset mid-load and mid-drain.
    send_words(12, 60, 0);
    rst_n = 1'b0;
    #1;
    check("t6 busy in reset",  64'(busy),  64'd0);
    check("t6 x_out in reset", 64'(x_out[WIDTH-1:0]), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    send_words(13, IN, 0);
    wait_valid(SETTLE, "t6 frame");
    out_handshakes(4);
    rst_n = 1'b0;
    #1;
    check("t6 out_valid in reset", 64'(out_valid), 64'd0);
    check("t6 out_data in reset",  64'(out_data),  64'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    send_words(14, IN, 0);
    wait_valid(SETTLE, "t6 after reset");
    drain_all("t6");

    repeat (6) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
